posit_decode_serial: RTL and testbench
======================================

// Module: posit_decode_serial
// PURPOSE
//  Unpacks one N-bit posit into sign, regime, exponent, combined scale and hidden-bit mantissa.
//  These are the same field formats the adder's rounding/packing stage consumes.
//  Serial, area-lean decoder: it walks the regime run one bit per clock, with a valid/ready
//  handshake on both sides. It sits at the front of the posit adder pipeline, feeding the
//  alignment stage.
// PARAMETERS
//  N   32          posit width in bits
//  ES  4           exponent field width in bits
//  RS  $clog2(N)   regime-count width; the regime output is RS+1 bits, signed
// PORTS
//  clk        in   1        clock; all state changes on the rising edge
//  nrst       in   1        asynchronous active-low reset
//  in_valid   in   1        in_posit is valid
//  in_ready   out  1        decoder can accept a posit; equals (state==IDLE)
//  in_posit   in   N        posit to decode; sampled only on the accept edge
//  out_valid  out  1        decoded fields are valid
//  out_ready  in   1        downstream accepts the decoded fields
//  sign       out  1        posit sign bit
//  regime     out  RS+1     signed regime value k
//  exp        out  ES       exponent field, zero-padded where truncated
//  scale      out  ES+RS+1  signed scale: k*2^ES + exp
//  mant       out  N        {1'b1, fraction, zeros}; fraction left-aligned below the hidden 1
//  zero       out  1        posit was 0
//  inf        out  1        posit was NaR, i.e. 1 followed by N-1 zeros
// BEHAVIOUR
//  - Reset (nrst low, async): state=IDLE; out_valid, sign, regime, exp, scale, mant, zero, inf
//    all 0. in_ready=1. Reset mid-decode abandons the operand; no output is produced for it.
//  - FSM states: IDLE, SCAN, DONE.
//  - IDLE, accept edge (in_valid && in_ready):
//    - Register mag = in_posit[N-1] ? -in_posit : in_posit. Register sign=in_posit[N-1].
//    - Register r0 = mag[N-2]. Load shreg = mag[N-2:0]. Clear cnt = 0.
//    - If in_posit==0: go to DONE with zero=1 and all other fields 0.
//    - Else if in_posit=={1,0..0}: go to DONE with inf=1, sign=1, other fields 0.
//    - Otherwise go to SCAN.
//  - SCAN, each edge:
//    - If shreg[N-2]==r0 and cnt<N-1: cnt++ and shreg <<= 1.
//    - Else go to DONE and register the fields:
//      - m=cnt; regime = r0 ? m-1 : -m.
//      - Drop the terminator bit (if cnt<N-1).
//      - exp = next ES bits, missing bits padded with 0.
//      - fraction = remaining bits.
//      - scale = (regime<<<ES) + exp; mant = {1, fraction, 0...}.
//  - DONE: out_valid=1. Outputs are held stable until out_ready. On out_valid && out_ready:
//    go to IDLE and clear out_valid. A new posit is accepted no earlier than the edge after
//    that (no overlap).
//  - Latency, counted in edges from the accept edge inclusive to out_valid high:
//    - zero or NaR: 1.
//    - Otherwise: m+2, where m = regime run length (1..N-1).
//  - in_posit changes while the decoder is not in IDLE are ignored.
//  - out_ready held high throughout gives a throughput of one posit per (latency+1) cycles.
//  - Arithmetic: regime and scale are two's complement. Their widths cover
//    k in [-(N-1), N-2] with no overflow.
// TESTING  (N=8, ES=1 unless stated)
//  1. in_posit=8'h56 -> 3 edges:
//     sign=0, regime=0, exp=1, scale=1, mant=8'b1011_0000, zero=0, inf=0.
//  2. in_posit=8'hAA (negation of 8'h56) -> 3 edges:
//     sign=1, regime=0, exp=1, scale=1, mant=8'b1011_0000.
//  3. Zero and NaR: in_posit=8'h00 -> 1 edge, zero=1, all other fields 0.
//     in_posit=8'h80 -> 1 edge, inf=1, sign=1.
//  4. Extremes:
//     in_posit=8'h7F -> 9 edges: regime=6, exp=0, scale=12, mant=8'h80.
//     in_posit=8'h01 -> 8 edges: regime=-6, exp=0, scale=-12, mant=8'h80.
//  5. Backpressure: decode 8'h56 with out_ready=0 for 5 cycles.
//     -> outputs stable; in_ready=0; in_valid with a new posit is ignored.
//     -> Raise out_ready: release in 1 edge; in_ready=1 on the next cycle.
//  6. Reset mid-SCAN (8'h7F, drop nrst after 3 edges): outputs 0 immediately, in_ready=1.
//     -> Then decode 8'h56 correctly.
//     -> Repeat cases 1/4 at N=32, ES=4 against the reference model.

Source files
------------

// File: rtl/posit_decode_serial_if.sv
// ---------------------------------------------------------------------------
// posit_decode_serial_if
// Bundles the upstream handshake (in_valid/in_ready/in_posit), the
// downstream handshake (out_valid/out_ready) and the decoded posit fields
// into one interface.
//   master : the environment around the decoder. It drives in_valid,
//            in_posit and out_ready, and observes everything else.
//   slave  : the decoder itself.
// Parameters N, ES and RS must match the ones given to the decoder.
// ---------------------------------------------------------------------------
interface posit_decode_serial_if #(
    parameter int N  = 32,
    parameter int ES = 4,
    parameter int RS = $clog2(N)
);
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_posit;
    logic              out_valid;
    logic              out_ready;
    logic              sign;
    logic [RS:0]       regime;
    logic [ES-1:0]     exp;
    logic [ES+RS:0]    scale;
    logic [N-1:0]      mant;
    logic              zero;
    logic              inf;

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, sign, regime, exp, scale, mant, zero, inf
    );

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, sign, regime, exp, scale, mant, zero, inf
    );
endinterface

// File: rtl/posit_decode_serial.sv
// ---------------------------------------------------------------------------
// posit_decode_serial
// Serial posit decoder. Takes one N-bit posit and unpacks it into sign,
// signed regime k, exponent, combined scale (k*2^ES + exp) and a mantissa
// with the hidden 1 at the MSB. The regime run is walked one bit per clock,
// so latency depends on the run length.
// Ports:
//   clk   : clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : posit_decode_serial_if.slave
//           in_valid/in_ready/in_posit  - operand handshake
//           out_valid/out_ready         - result handshake
//           sign, regime, exp, scale, mant, zero, inf - decoded fields
// ---------------------------------------------------------------------------
module posit_decode_serial #(
    parameter int N  = 32,
    parameter int ES = 4,
    parameter int RS = $clog2(N)
) (
    input  logic                clk,
    input  logic                nrst,
    posit_decode_serial_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [N-1:0]  NAR      = {1'b1, {(N-1){1'b0}}};
    localparam logic [RS-1:0] CNT_MAX  = RS'(N-1);
    localparam logic [RS-1:0] CNT_ONE  = RS'(1);
    localparam logic [RS:0]   REG_ONE  = (RS+1)'(1);
    localparam logic [N-2:0]  MAG_ONE  = (N-1)'(1);

    state_t          state;
    logic [N-2:0]    shreg;
    logic [RS-1:0]   cnt;
    logic            r0;
    logic            sign_q;
    logic [RS:0]     regime_q;
    logic [ES-1:0]   exp_q;
    logic [N-1:0]    mant_q;
    logic            zero_q;
    logic            inf_q;
    logic            out_valid_q;

    logic [N-2:0]    mag_low;
    logic [N-2:0]    rest;
    logic [RS:0]     regime_c;
    logic            run_continues;

    // Only the bits below the sign are needed from the magnitude; the low
    // N-1 bits of a two's complement negation depend only on the low N-1
    // bits of the operand.
    always_comb begin
        mag_low = bus.in_posit[N-2:0];
        if (bus.in_posit[N-1]) begin
            mag_low = ~bus.in_posit[N-2:0] + MAG_ONE;
        end
    end

    // While scanning, the MSB of shreg is the bit under inspection. When the
    // run ends that bit is the terminator, which is shifted out so that the
    // exponent and fraction sit left-aligned in rest. A run that fills the
    // whole body has no terminator to drop.
    always_comb begin
        run_continues = (shreg[N-2] == r0) && (cnt < CNT_MAX);
        rest          = shreg;
        if (cnt < CNT_MAX) begin
            rest = shreg << 1;
        end
        regime_c = r0 ? ({1'b0, cnt} - REG_ONE) : -{1'b0, cnt};
    end

    // Control FSM. Output fields are only written when a result is
    // produced, so they stay stable for the whole time out_valid is high.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            r0          <= 1'b0;
            sign_q      <= 1'b0;
            regime_q    <= '0;
            exp_q       <= '0;
            mant_q      <= '0;
            zero_q      <= 1'b0;
            inf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= bus.in_posit[N-1];
                        r0     <= mag_low[N-2];
                        shreg  <= mag_low;
                        cnt    <= '0;
                        if (bus.in_posit == '0) begin
                            zero_q      <= 1'b1;
                            inf_q       <= 1'b0;
                            regime_q    <= '0;
                            exp_q       <= '0;
                            mant_q      <= '0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else if (bus.in_posit == NAR) begin
                            zero_q      <= 1'b0;
                            inf_q       <= 1'b1;
                            regime_q    <= '0;
                            exp_q       <= '0;
                            mant_q      <= '0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (run_continues) begin
                        cnt   <= cnt + CNT_ONE;
                        shreg <= shreg << 1;
                    end else begin
                        regime_q    <= regime_c;
                        exp_q       <= rest[N-2 -: ES];
                        mant_q      <= {1'b1, rest[N-2-ES:0], {ES{1'b0}}};
                        zero_q      <= 1'b0;
                        inf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The low ES bits of k*2^ES are zero, so the scale is simply the
    // regime with the exponent appended.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sign      = sign_q;
    assign bus.regime    = regime_q;
    assign bus.exp       = exp_q;
    assign bus.scale     = {regime_q, exp_q};
    assign bus.mant      = mant_q;
    assign bus.zero      = zero_q;
    assign bus.inf       = inf_q;

endmodule

// File: tb/tb_posit_decode_serial.sv
// ---------------------------------------------------------------------------
// tb_posit_decode_serial
// Drives an N=8/ES=1 decoder from a table of hand-computed vectors, runs the
// backpressure and mid-scan reset sequences on it, and checks an
// N=32/ES=4 decoder against a bit-indexing reference model.
// ---------------------------------------------------------------------------
module tb_posit_decode_serial;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    always #5 clk = ~clk;

    posit_decode_serial_if #(.N(8),  .ES(1), .RS(3)) bus8 ();
    posit_decode_serial_if #(.N(32), .ES(4), .RS(5)) bus32 ();

    posit_decode_serial #(.N(8), .ES(1), .RS(3)) dut8 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus8)
    );

    posit_decode_serial #(.N(32), .ES(4), .RS(5)) dut32 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus32)
    );

    typedef struct {
        logic [7:0] posit;
        int         lat;
        logic       sign;
        logic [3:0] regime;
        logic       exp;
        logic [4:0] scale;
        logic [7:0] mant;
        logic       zero;
        logic       inf;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Compare one value and report a mismatch.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Offer one posit to the 8-bit decoder and count edges, accept edge
    // included, until out_valid is seen.
    task automatic apply_stimulus8(input logic [7:0] p, output int lat);
        check_output($sformatf("in_ready8 before %02h", p), 64'(bus8.in_ready), 64'd1);
        bus8.in_valid = 1'b1;
        bus8.in_posit = p;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic apply_stimulus32(input logic [31:0] p, output int lat);
        check_output($sformatf("in_ready32 before %08h", p), 64'(bus32.in_ready), 64'd1);
        bus32.in_valid = 1'b1;
        bus32.in_posit = p;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 1;
        while (!bus32.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Reference decode for N=32, ES=4 working on bit positions of the
    // magnitude rather than a shifting register.
    task automatic model32(input logic [31:0] p, output int lat, output logic s, output int k,
                           output int e, output int sc, output logic [31:0] m,
                           output logic z, output logic nar);
        logic [31:0] mg;
        logic [30:0] b;
        int run, idx, dst;
        z   = (p == 32'h0);
        nar = (p == 32'h8000_0000);
        s   = p[31];
        k   = 0;
        e   = 0;
        sc  = 0;
        m   = '0;
        lat = 1;
        if (!z && !nar) begin
            mg  = p[31] ? -p : p;
            b   = mg[30:0];
            run = 0;
            while (run < 31 && b[30-run] == b[30]) run++;
            k   = b[30] ? run - 1 : -run;
            lat = run + 2;
            idx = 30 - run;
            for (int j = 0; j < 4; j++) begin
                e = e * 2;
                if (idx - 1 - j >= 0) begin
                    if (b[idx-1-j]) e = e + 1;
                end
            end
            sc    = k * 16 + e;
            m[31] = 1'b1;
            dst   = 30;
            for (int pos = idx - 5; pos >= 0; pos--) begin
                m[dst] = b[pos];
                dst--;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs [13];
        logic [31:0] v32  [12];
        int          lat;
        int          m_lat, m_k, m_e, m_sc;
        logic        m_s, m_z, m_nar;
        logic [31:0] m_mant;

        //                posit  lat sign reg   exp   scale  mant   zero  inf
        vecs[0]  = '{8'h56, 3, 1'b0, 4'h0, 1'b1, 5'h01, 8'hB0, 1'b0, 1'b0};
        vecs[1]  = '{8'hAA, 3, 1'b1, 4'h0, 1'b1, 5'h01, 8'hB0, 1'b0, 1'b0};
        vecs[2]  = '{8'h00, 1, 1'b0, 4'h0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h80, 1, 1'b1, 4'h0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{8'h7F, 9, 1'b0, 4'h6, 1'b0, 5'h0C, 8'h80, 1'b0, 1'b0};
        vecs[5]  = '{8'h01, 8, 1'b0, 4'hA, 1'b0, 5'h14, 8'h80, 1'b0, 1'b0};
        vecs[6]  = '{8'h40, 3, 1'b0, 4'h0, 1'b0, 5'h00, 8'h80, 1'b0, 1'b0};
        vecs[7]  = '{8'h20, 3, 1'b0, 4'hF, 1'b0, 5'h1E, 8'h80, 1'b0, 1'b0};
        vecs[8]  = '{8'h60, 4, 1'b0, 4'h1, 1'b0, 5'h02, 8'h80, 1'b0, 1'b0};
        vecs[9]  = '{8'hC0, 3, 1'b1, 4'h0, 1'b0, 5'h00, 8'h80, 1'b0, 1'b0};
        vecs[10] = '{8'h03, 7, 1'b0, 4'hB, 1'b1, 5'h17, 8'h80, 1'b0, 1'b0};
        vecs[11] = '{8'h4B, 3, 1'b0, 4'h0, 1'b0, 5'h00, 8'hD8, 1'b0, 1'b0};
        vecs[12] = '{8'h7E, 8, 1'b0, 4'h5, 1'b0, 5'h0A, 8'h80, 1'b0, 1'b0};

        v32[0]  = 32'h7FFF_FFFF;
        v32[1]  = 32'h0000_0001;
        v32[2]  = 32'h4000_0000;
        v32[3]  = 32'h5678_9ABC;
        v32[4]  = 32'hA987_6544;
        v32[5]  = 32'h0000_0000;
        v32[6]  = 32'h8000_0000;
        v32[7]  = 32'hFFFF_FFFF;
        for (int i = 8; i < 12; i++) v32[i] = $urandom;

        bus8.in_valid   = 1'b0;
        bus8.in_posit   = '0;
        bus8.out_ready  = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_posit  = '0;
        bus32.out_ready = 1'b1;

        // Reset state
        #12;
        check_output("reset out_valid", 64'(bus8.out_valid), 64'd0);
        check_output("reset in_ready",  64'(bus8.in_ready),  64'd1);
        check_output("reset fields",
                     64'({bus8.sign, bus8.regime, bus8.exp, bus8.scale, bus8.mant, bus8.zero, bus8.inf}),
                     64'd0);
        check_output("reset32 fields", 64'({bus32.out_valid, bus32.mant, bus32.scale}), 64'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // Table of 8-bit vectors
        for (int i = 0; i < 13; i++) begin
            apply_stimulus8(vecs[i].posit, lat);
            check_output($sformatf("lat %02h",    vecs[i].posit), 64'(lat),          64'(vecs[i].lat));
            check_output($sformatf("sign %02h",   vecs[i].posit), 64'(bus8.sign),    64'(vecs[i].sign));
            check_output($sformatf("regime %02h", vecs[i].posit), 64'(bus8.regime),  64'(vecs[i].regime));
            check_output($sformatf("exp %02h",    vecs[i].posit), 64'(bus8.exp),     64'(vecs[i].exp));
            check_output($sformatf("scale %02h",  vecs[i].posit), 64'(bus8.scale),   64'(vecs[i].scale));
            check_output($sformatf("mant %02h",   vecs[i].posit), 64'(bus8.mant),    64'(vecs[i].mant));
            check_output($sformatf("zero %02h",   vecs[i].posit), 64'(bus8.zero),    64'(vecs[i].zero));
            check_output($sformatf("inf %02h",    vecs[i].posit), 64'(bus8.inf),     64'(vecs[i].inf));
            @(posedge clk); #1;
        end

        // Backpressure: result must hold while out_ready is low and a new
        // posit offered meanwhile must be ignored.
        bus8.out_ready = 1'b0;
        apply_stimulus8(8'h56, lat);
        check_output("bp lat", 64'(lat), 64'd3);
        bus8.in_valid = 1'b1;
        bus8.in_posit = 8'h7F;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_output($sformatf("bp out_valid c%0d", c), 64'(bus8.out_valid), 64'd1);
            check_output($sformatf("bp in_ready c%0d", c),  64'(bus8.in_ready),  64'd0);
            check_output($sformatf("bp fields c%0d", c),
                         64'({bus8.mant, bus8.scale, bus8.regime}), 64'({8'hB0, 5'h01, 4'h0}));
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("bp release out_valid", 64'(bus8.out_valid), 64'd0);
        check_output("bp release in_ready",  64'(bus8.in_ready),  64'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_output($sformatf("bp no phantom c%0d", c), 64'(bus8.out_valid), 64'd0);
        end

        // Reset in the middle of scanning 8'h7F
        bus8.in_valid = 1'b1;
        bus8.in_posit = 8'h7F;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("scan busy in_ready", 64'(bus8.in_ready), 64'd0);
        nrst = 1'b0;
        #1;
        check_output("midrst in_ready",  64'(bus8.in_ready),  64'd1);
        check_output("midrst out_valid", 64'(bus8.out_valid), 64'd0);
        check_output("midrst fields",
                     64'({bus8.sign, bus8.regime, bus8.exp, bus8.scale, bus8.mant, bus8.zero, bus8.inf}),
                     64'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        apply_stimulus8(8'h56, lat);
        check_output("post-rst lat", 64'(lat), 64'd3);
        check_output("post-rst fields",
                     64'({bus8.sign, bus8.regime, bus8.exp, bus8.scale, bus8.mant}),
                     64'({1'b0, 4'h0, 1'b1, 5'h01, 8'hB0}));
        @(posedge clk); #1;

        // 32-bit decoder against the reference model
        for (int i = 0; i < 12; i++) begin
            model32(v32[i], m_lat, m_s, m_k, m_e, m_sc, m_mant, m_z, m_nar);
            apply_stimulus32(v32[i], lat);
            check_output($sformatf("lat32 %08h",    v32[i]), 64'(lat),                    64'(m_lat));
            check_output($sformatf("sign32 %08h",   v32[i]), 64'(bus32.sign),             64'(m_s));
            check_output($sformatf("regime32 %08h", v32[i]), 64'($signed(bus32.regime)), 64'(m_k));
            check_output($sformatf("exp32 %08h",    v32[i]), 64'(bus32.exp),              64'(m_e));
            check_output($sformatf("scale32 %08h",  v32[i]), 64'($signed(bus32.scale)),  64'(m_sc));
            check_output($sformatf("mant32 %08h",   v32[i]), 64'(bus32.mant),             64'(m_mant));
            check_output($sformatf("flags32 %08h",  v32[i]), 64'({bus32.zero, bus32.inf}), 64'({m_z, m_nar}));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
